// File: rtl/contour_pkg.sv
// Shared types and constants for the pitch contour classifier.
package contour_pkg;

    typedef enum logic [2:0] {
        CLS_NEUTRAL    = 3'd0,
        CLS_RISING     = 3'd1,
        CLS_FALLING    = 3'd2,
        CLS_PEAKING    = 3'd3,
        CLS_DIPPING    = 3'd4,
        CLS_UNDULATING = 3'd5
    } contour_class_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CAPTURE  = 3'd1,
        ST_COMPARE  = 3'd2,
        ST_CLASSIFY = 3'd3,
        ST_REPORT   = 3'd4
    } contour_state_t;

    // Two-bit step codes; the low bit flags "significant", the high bit the sign.
    localparam logic [1:0] STEP_FLAT = 2'b00;
    localparam logic [1:0] STEP_UP   = 2'b01;
    localparam logic [1:0] STEP_DOWN = 2'b11;

endpackage

// File: rtl/contour_step_quantizer.sv
// Quantises one frame-to-frame pitch step as flat/up/down against a
// percentage threshold. Relative change is tested by cross-multiplying
// (|d|*100 >= prev*THRESH_PCT), so no divider and no divide-by-zero case:
// prev = 0 with any rise yields lim = 0 and counts as up.
module contour_step_quantizer
    import contour_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int THRESH_PCT = 20
) (
    input  logic [WIDTH-1:0] prev_i,
    input  logic [WIDTH-1:0] cur_i,
    output logic [1:0]       step_o
);

    logic signed [WIDTH:0]   d;
    logic signed [WIDTH:0]   nd;
    logic        [WIDTH-1:0] absd;
    logic        [WIDTH+7:0] mag;
    logic        [WIDTH+6:0] lim;

    // Full-width difference, magnitude and threshold; nothing is truncated.
    always_comb begin
        d      = $signed({1'b0, cur_i}) - $signed({1'b0, prev_i});
        nd     = -d;
        absd   = d[WIDTH] ? nd[WIDTH-1:0] : d[WIDTH-1:0];
        mag    = (WIDTH+8)'(absd) * (WIDTH+8)'(100);
        lim    = (WIDTH+7)'(prev_i) * (WIDTH+7)'(THRESH_PCT);
        step_o = STEP_FLAT;
        if ((d != '0) && (mag >= {1'b0, lim}))
            step_o = d[WIDTH] ? STEP_DOWN : STEP_UP;
    end

endmodule

// File: rtl/pitch_contour_classifier.sv
// Captures N_FRAMES pitch samples, quantises each step with a single
// time-shared quantiser (one step per COMPARE cycle), classifies the
// contour and holds the result behind a valid/ready handshake.
module pitch_contour_classifier
    import contour_pkg::*;
#(
    parameter int          WIDTH          = 16,
    parameter int          N_FRAMES       = 4,
    parameter int          THRESH_PCT     = 20,
    parameter int unsigned TIMEOUT_CYCLES = 32'd1_000_000
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    input  logic                    start_in,
    input  logic                    abort_in,
    input  logic [WIDTH-1:0]        pitch_in,
    input  logic                    pitch_valid_in,
    output logic                    pitch_ready_out,
    output logic [2:0]              class_out,
    output logic [2*(N_FRAMES-1)-1:0] steps_out,
    output logic                    valid_out,
    input  logic                    ready_in,
    output logic                    busy_out,
    output logic                    timeout_out
);

    localparam int S  = N_FRAMES - 1;
    localparam int IW = $clog2(N_FRAMES);
    localparam logic [4:0] QS = 5'(S / 4);

    contour_state_t   state_q, state_d;
    logic [WIDTH-1:0] smp_q [N_FRAMES];
    logic [WIDTH-1:0] smp_d [N_FRAMES];
    logic [IW-1:0]    idx_q, idx_d;
    logic [IW-1:0]    k_q, k_d;
    logic [31:0]      gap_q, gap_d;
    logic             timeout_q, timeout_d;
    logic [2*S-1:0]   acc_q, acc_d;
    logic [2*S-1:0]   steps_q, steps_d;
    contour_class_t   class_q, class_d;
    logic             valid_q, valid_d;

    logic             accept;
    logic             handshake;
    logic [1:0]       step_c;
    contour_class_t   cls_c;

    assign accept    = (state_q == ST_CAPTURE) && pitch_valid_in;
    assign handshake = valid_q && ready_in;

    contour_step_quantizer #(
        .WIDTH      (WIDTH),
        .THRESH_PCT (THRESH_PCT)
    ) u_quant (
        .prev_i (smp_q[k_q]),
        .cur_i  (smp_q[k_q + IW'(1)]),
        .step_o (step_c)
    );

    // Contour class from the accumulated step codes, rules in priority order.
    always_comb begin
        logic [4:0] n_up, n_dn;
        logic [1:0] first_s, last_s, st;
        logic       seen;
        n_up    = '0;
        n_dn    = '0;
        first_s = STEP_FLAT;
        last_s  = STEP_FLAT;
        seen    = 1'b0;
        st      = STEP_FLAT;
        for (int i = 0; i < S; i++) begin
            st = acc_q[2*i +: 2];
            if (st == STEP_UP)   n_up = n_up + 5'd1;
            if (st == STEP_DOWN) n_dn = n_dn + 5'd1;
            if (st != STEP_FLAT) begin
                if (!seen) first_s = st;
                seen   = 1'b1;
                last_s = st;
            end
        end
        if (n_up == '0 && n_dn == '0)                          cls_c = CLS_NEUTRAL;
        else if (n_up > n_dn && n_dn <= QS)                    cls_c = CLS_RISING;
        else if (n_dn > n_up && n_up <= QS)                    cls_c = CLS_FALLING;
        else if (first_s == STEP_UP && last_s == STEP_DOWN)    cls_c = CLS_PEAKING;
        else if (first_s == STEP_DOWN && last_s == STEP_UP)    cls_c = CLS_DIPPING;
        else                                                   cls_c = CLS_UNDULATING;
    end

    // Next-state logic; abort wins over every other event.
    always_comb begin
        state_d   = state_q;
        smp_d     = smp_q;
        idx_d     = idx_q;
        k_d       = k_q;
        gap_d     = gap_q;
        timeout_d = timeout_q;
        acc_d     = acc_q;
        steps_d   = steps_q;
        class_d   = class_q;
        if (abort_in) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            k_d     = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        state_d   = ST_CAPTURE;
                        idx_d     = '0;
                        gap_d     = '0;
                        timeout_d = 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    if (accept) begin
                        smp_d[idx_q] = pitch_in;
                        gap_d        = '0;
                        if (idx_q == IW'(N_FRAMES - 1)) begin
                            state_d = ST_COMPARE;
                            idx_d   = '0;
                            k_d     = '0;
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else if (gap_q >= TIMEOUT_CYCLES - 32'd1) begin
                        timeout_d = 1'b1;
                        state_d   = ST_IDLE;
                        idx_d     = '0;
                    end else begin
                        gap_d = gap_q + 32'd1;
                    end
                end
                ST_COMPARE: begin
                    acc_d[2*k_q +: 2] = step_c;
                    if (k_q == IW'(S - 1)) begin
                        k_d     = '0;
                        state_d = ST_CLASSIFY;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
                ST_CLASSIFY: begin
                    class_d = cls_c;
                    steps_d = acc_q;
                    state_d = ST_REPORT;
                end
                ST_REPORT: begin
                    if (handshake) begin
                        if (start_in) begin
                            state_d   = ST_CAPTURE;
                            idx_d     = '0;
                            gap_d     = '0;
                            timeout_d = 1'b0;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // valid is registered one cycle into REPORT so it drives from a flop
        valid_d = (state_q == ST_REPORT) && !handshake && !abort_in;
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < N_FRAMES; i++) smp_q[i] <= '0;
            idx_q     <= '0;
            k_q       <= '0;
            gap_q     <= '0;
            timeout_q <= 1'b0;
            acc_q     <= '0;
            steps_q   <= '0;
            class_q   <= CLS_NEUTRAL;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            smp_q     <= smp_d;
            idx_q     <= idx_d;
            k_q       <= k_d;
            gap_q     <= gap_d;
            timeout_q <= timeout_d;
            acc_q     <= acc_d;
            steps_q   <= steps_d;
            class_q   <= class_d;
            valid_q   <= valid_d;
        end
    end

    assign pitch_ready_out = (state_q == ST_CAPTURE);
    assign busy_out        = (state_q != ST_IDLE);
    assign valid_out       = valid_q;
    assign class_out       = class_q;
    assign steps_out       = steps_q;
    assign timeout_out     = timeout_q;

endmodule

// File: tb/tb_pitch_contour_classifier.sv
// Directed and randomised bench for pitch_contour_classifier.
module tb_pitch_contour_classifier;

    localparam int W  = 16;
    localparam int NF = 4;
    localparam int S  = NF - 1;
    localparam int TH = 20;
    localparam int TO = 8;

    logic           clk_in = 1'b0;
    logic           rst_n_in = 1'b0;
    logic           start_in = 1'b0;
    logic           abort_in = 1'b0;
    logic [W-1:0]   pitch_in = '0;
    logic           pitch_valid_in = 1'b0;
    logic           ready_in = 1'b0;
    logic           pitch_ready_out, valid_out, busy_out, timeout_out;
    logic [2:0]     class_out;
    logic [2*S-1:0] steps_out;

    int checks = 0;
    int errors = 0;

    pitch_contour_classifier #(
        .WIDTH(W), .N_FRAMES(NF), .THRESH_PCT(TH), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .start_in(start_in), .abort_in(abort_in),
        .pitch_in(pitch_in), .pitch_valid_in(pitch_valid_in), .pitch_ready_out(pitch_ready_out),
        .class_out(class_out), .steps_out(steps_out), .valid_out(valid_out), .ready_in(ready_in),
        .busy_out(busy_out), .timeout_out(timeout_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: relative change >= TH percent is a significant step; class by rule list.
    function automatic void model(input int unsigned v[NF], output logic [2*S-1:0] st, output int cls);
        int u, dn;
        int nz[$];
        longint p, c, dd, a;
        u = 0; dn = 0; st = '0;
        for (int k = 0; k < S; k++) begin
            p = v[k]; c = v[k+1]; dd = c - p; a = (dd < 0) ? -dd : dd;
            if (dd != 0 && a * 100 >= p * TH) begin
                if (dd > 0) begin st[2*k +: 2] = 2'b01; u++;  nz.push_back(1);  end
                else        begin st[2*k +: 2] = 2'b11; dn++; nz.push_back(-1); end
            end
        end
        if (u == 0 && dn == 0)                      cls = 0;
        else if (u > dn && dn <= S / 4)             cls = 1;
        else if (dn > u && u <= S / 4)              cls = 2;
        else if (nz[0] == 1 && nz[$] == -1)         cls = 3;
        else if (nz[0] == -1 && nz[$] == 1)         cls = 4;
        else                                        cls = 5;
    endfunction

    task automatic send(input int unsigned v[NF], input int n, input bit noisy);
        for (int i = 0; i < n; i++) begin
            if (noisy) begin
                repeat ($urandom_range(0, 3)) begin
                    start_in = 1'($urandom_range(0, 1));
                    tick();
                end
            end
            pitch_valid_in = 1'b1;
            pitch_in = W'(v[i]);
            start_in = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
            tick();
            pitch_valid_in = 1'b0;
            start_in = 1'b0;
        end
    endtask

    // Run one contour (optionally arming first) and check latency and result.
    task automatic do_frame(input string tag, input int unsigned v[NF], input logic [2*S-1:0] est,
                            input int ecls, input bit arm, input bit noisy);
        int n;
        if (arm) begin
            start_in = 1'b1;
            tick();
            start_in = 1'b0;
        end
        chk({tag, "_rdy"}, 32'(pitch_ready_out), 32'd1);
        send(v, NF, noisy);
        n = 0;
        while (!valid_out && n < 40) begin
            tick();
            n++;
        end
        chk({tag, "_lat"}, n, S + 2);
        chk({tag, "_cls"}, 32'(class_out), ecls);
        chk({tag, "_steps"}, 32'(steps_out), 32'(est));
    endtask

    task automatic ack(input string tag);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        chk({tag, "_vld0"}, 32'(valid_out), 32'd0);
        chk({tag, "_idle"}, 32'(busy_out), 32'd0);
    endtask

    initial begin
        int unsigned v[NF];
        logic [2*S-1:0] est;
        int ecls, n;
        bit saw_valid;

        // reset state
        repeat (3) tick();
        chk("rst_ready", 32'(pitch_ready_out), 0);
        chk("rst_busy", 32'(busy_out), 0);
        chk("rst_valid", 32'(valid_out), 0);
        chk("rst_timeout", 32'(timeout_out), 0);
        chk("rst_class", 32'(class_out), 0);
        chk("rst_steps", 32'(steps_out), 0);
        rst_n_in = 1'b1;
        tick();

        // sample offered in IDLE is not consumed
        pitch_valid_in = 1'b1; pitch_in = 16'd999;
        tick(); tick();
        chk("idle_noready", 32'(pitch_ready_out), 0);
        chk("idle_nobusy", 32'(busy_out), 0);
        pitch_valid_in = 1'b0;

        v = '{100, 130, 170, 220}; do_frame("rise", v, 6'b010101, 1, 1, 0); ack("rise");
        v = '{100, 120, 120, 120}; do_frame("th_eq", v, 6'b000001, 1, 1, 0); ack("th_eq");
        v = '{100, 119, 119, 119}; do_frame("th_lo", v, 6'b000000, 0, 1, 0); ack("th_lo");
        v = '{200, 120, 120, 200}; do_frame("dip", v, 6'b010011, 4, 1, 0); ack("dip");
        v = '{100, 150, 150, 100}; do_frame("peak", v, 6'b110001, 3, 1, 0);

        // backpressure: result held stable, then re-arm on the handshake cycle
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid", 32'(valid_out), 1);
            chk("bp_class", 32'(class_out), 3);
            chk("bp_steps", 32'(steps_out), 32'(6'b110001));
        end
        ready_in = 1'b1; start_in = 1'b1;
        tick();
        ready_in = 1'b0; start_in = 1'b0;
        chk("rearm_capture", 32'(pitch_ready_out), 1);
        chk("rearm_vld0", 32'(valid_out), 0);
        v = '{100, 150, 100, 150}; do_frame("undul", v, 6'b011101, 5, 0, 0); ack("undul");
        v = '{0, 0, 50, 50}; do_frame("zero", v, 6'b000100, 1, 1, 0); ack("zero");

        // timeout after TO idle cycles in CAPTURE
        start_in = 1'b1; tick(); start_in = 1'b0;
        v = '{300, 310, 0, 0};
        send(v, 2, 0);
        n = 0; saw_valid = 0;
        while (!timeout_out && n < 40) begin
            tick();
            n++;
            if (valid_out) saw_valid = 1;
        end
        chk("to_cycles", n, TO);
        chk("to_novalid", 32'(saw_valid), 0);
        chk("to_idle", 32'(busy_out), 0);
        start_in = 1'b1; tick(); start_in = 1'b0;
        chk("to_clear", 32'(timeout_out), 0);

        // abort during COMPARE; outputs keep the last reported result
        v = '{100, 200, 300, 400};
        send(v, NF, 0);
        tick();
        abort_in = 1'b1; tick(); abort_in = 1'b0;
        chk("abort_idle", 32'(busy_out), 0);
        saw_valid = 0;
        repeat (8) begin
            tick();
            if (valid_out) saw_valid = 1;
        end
        chk("abort_novalid", 32'(saw_valid), 0);
        chk("abort_nto", 32'(timeout_out), 0);
        chk("abort_cls_kept", 32'(class_out), 1);
        chk("abort_steps_kept", 32'(steps_out), 32'(6'b000100));

        // asynchronous reset mid-CAPTURE
        start_in = 1'b1; tick(); start_in = 1'b0;
        v = '{50, 0, 0, 0};
        send(v, 1, 0);
        chk("pre_rst_rdy", 32'(pitch_ready_out), 1);
        #2 rst_n_in = 1'b0;
        #1;
        chk("arst_ready", 32'(pitch_ready_out), 0);
        chk("arst_busy", 32'(busy_out), 0);
        chk("arst_class", 32'(class_out), 0);
        chk("arst_steps", 32'(steps_out), 0);
        chk("arst_valid", 32'(valid_out), 0);
        tick();
        rst_n_in = 1'b1;
        tick();

        // randomised contours with noise on start_in and gaps while capturing
        for (int t = 0; t < 40; t++) begin
            v[0] = $urandom_range(0, 400);
            for (int i = 1; i < NF; i++) begin
                case ($urandom_range(0, 3))
                    0: v[i] = v[i-1];
                    1: v[i] = v[i-1] + v[i-1] / 5;
                    2: v[i] = v[i-1] - v[i-1] / 5;
                    default: v[i] = $urandom_range(0, 400);
                endcase
            end
            model(v, est, ecls);
            do_frame("rnd", v, est, ecls, 1, 1);
            ack("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pitch_contour_classifier.md
Name: pitch_contour_classifier

Overview:
- Parametrised successor to the fixed four-frame tone detector; sits between the FFT peak-bin extractor and the tone/word decision logic.
- Captures N_FRAMES pitch estimates, quantises each frame-to-frame step as up/flat/down against a percentage threshold, classifies the contour into one of six classes and holds the result behind a valid/ready handshake.
- Uses a cross-multiply compare instead of a divider, so there is no IP latency and no divide-by-zero hazard.

Parameters:
- WIDTH, 16, unsigned pitch value width (bin index or Hz).
- N_FRAMES, 4, frames per contour; legal range 3..16; S = N_FRAMES-1 steps.
- THRESH_PCT, 20, minimum relative change in percent for a step to count as significant; legal range 1..100.
- TIMEOUT_CYCLES, 32'd1_000_000, maximum gap allowed between accepted samples while capturing.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous assert, active-low.
- start_in  input  1  arms a capture; honoured only in IDLE, or in REPORT on the same cycle as the output handshake.
- abort_in  input  1  returns the block to IDLE from any state and discards its data.
- pitch_in  input  WIDTH  pitch sample.
- pitch_valid_in  input  1  sample valid.
- pitch_ready_out  output  1  high only in CAPTURE.
- class_out  output  3  0 NEUTRAL, 1 RISING, 2 FALLING, 3 PEAKING, 4 DIPPING, 5 UNDULATING.
- steps_out  output  2*S  per-step codes: 00 flat, 01 up, 11 down; bits [1:0] hold the earliest step.
- valid_out  output  1  result valid; held high until the handshake.
- ready_in  input  1  downstream ready.
- busy_out  output  1  high in any state other than IDLE.
- timeout_out  output  1  sticky error flag; cleared by the next accepted start_in.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the sample buffer, counters and step register are cleared.
- States and transitions:
  - IDLE: start_in moves to CAPTURE.
  - CAPTURE: each pitch_valid_in && pitch_ready_out cycle writes buf[idx] and increments idx. The N_FRAMES-th accept moves to COMPARE.
  - COMPARE: processes one step k per cycle, for k = 0..S-1, using prev = buf[k] and cur = buf[k+1]. After S cycles, moves to CLASSIFY.
  - CLASSIFY: one cycle; registers class_out and steps_out, then moves to REPORT.
  - REPORT: valid_out = 1. On valid_out && ready_in, moves to IDLE, or to CAPTURE if start_in is high on the same cycle.
- Latency: valid_out rises S+2 edges after the edge that accepts the final sample.
- Step arithmetic:
  - d = cur - prev, signed WIDTH+1 bits.
  - mag = |d| * 100, WIDTH+8 bits.
  - lim = prev * THRESH_PCT, WIDTH+7 bits, zero-extended before the compare.
  - If mag >= lim and d != 0, the step is significant; its sign gives 01 (up) or 11 (down). Otherwise the step is 00.
  - prev = 0 with cur > 0 gives 01. prev = cur = 0 gives 00.
  - No truncation is allowed anywhere in this path.
- Classification, applied in priority order, with U = count of ups and D = count of downs:
  1. U = D = 0 → NEUTRAL.
  2. U > D and D <= S/4 (integer division) → RISING.
  3. D > U and U <= S/4 → FALLING.
  4. First non-flat step up and last non-flat step down → PEAKING.
  5. First non-flat step down and last non-flat step up → DIPPING.
  6. Otherwise → UNDULATING.
- Timeout: a gap counter resets on start and on each accept. If it reaches TIMEOUT_CYCLES while in CAPTURE, timeout_out is set, the buffer is discarded and the state goes to IDLE; valid_out is not asserted.
- Boundary conditions:
  - abort_in overrides every other event in the same cycle and does not set timeout_out.
  - start_in is ignored in CAPTURE, COMPARE and CLASSIFY.
  - A pitch_valid_in outside CAPTURE is not consumed.
  - class_out and steps_out stay stable from CLASSIFY through the handshake and keep their last values in IDLE.
  - Asserting reset mid-operation clears everything immediately, with no output glitch beyond the async clear.

Decomposition:
- Package contour_pkg holds:
  - the class enum contour_class_t (3-bit values as listed under class_out);
  - the state enum contour_state_t (IDLE, CAPTURE, COMPARE, CLASSIFY, REPORT);
  - the step code constants STEP_FLAT, STEP_UP, STEP_DOWN.
- Sub-module contour_step_quantizer is combinational. It takes prev, cur and THRESH_PCT and returns the 2-bit step code. It is unit-testable on its own and is instantiated once, time-shared across the COMPARE cycles.

Test Plan (defaults: N_FRAMES=4, THRESH_PCT=20):
- Rising: start, then samples 100, 130, 170, 220 → steps_out = 01_01_01, class_out = 1, valid_out rises exactly 5 edges after the 4th accept.
- Threshold edge: samples 100, 120, 120, 120 → first step 01 (exactly 20% counts); samples 100, 119, 119, 119 → all 00, class NEUTRAL.
- Peaking and dipping:
  - samples 100, 150, 150, 100 → steps 11_00_01, class 3;
  - samples 200, 120, 120, 200 → steps 01_00_11, class 4.
- Undulating and zero handling:
  - samples 100, 150, 100, 150 → steps 01_11_01, class 5;
  - samples 0, 0, 50, 50 → steps 00_01_00, class RISING.
- Backpressure and re-arm: hold ready_in = 0 for 10 cycles → valid_out, class_out and steps_out are stable throughout; raise ready_in with start_in high → next cycle is CAPTURE and pitch_ready_out = 1.
- Timeout, abort and reset:
  - TIMEOUT_CYCLES = 8, 2 samples then idle → timeout_out = 1 and state IDLE after 8 cycles, valid_out never asserted;
  - abort_in during COMPARE → IDLE next cycle;
  - rst_n_in low mid-CAPTURE → all outputs 0 asynchronously.
